block_transfer_sequencer: RTL and testbench

Multi-cycle sequencer for the LDM/STM block-transfer instructions. It is the initiator on the register-file port: it walks a 16-bit register list, driving register addresses and write strobes into the register file and addresses and write strobes into data memory, one register per clock. It sits beside the single-cycle datapath and holds the core in stall while a transfer runs.

---
 rtl/block_transfer_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_transfer_sequencer.sv
// Purpose : LDM/STM block-transfer sequencer; walks a 16-bit register list and moves one register per cycle between the register file and data memory.
// Latency : Start accepted at edge k -> XFER cycles k+1..k+N, FINISH (Done) at k+N+1; N = popcount(RegList), N = 0 gives FINISH only.
// Backpres: none; Busy stalls the core while a transfer runs, and Start is sampled only in IDLE.
//
// Ports:
//   CLK, reset          clock and synchronous active-high reset
//   Start/Load/Up/W/Rn  request and its mode, captured in the Start cycle
//   Base, RegList       base register value and register list, captured in the Start cycle
//   RD, MemRD           register-file and data-memory read data (used live)
//   RegA/RegWE/RegWD    register-file address (read and write) and write port
//   PCWE/PCWD           PC load when R15 is the LDM destination
//   MemAddr/MemWE/MemWD data-memory address and write port
//   Busy, Done          stall request and one-cycle completion pulse
//
// Build option: define BLKXFER_WRITEBACK_EN to honour W (base writeback in FINISH).
// Without it, W and Rn are ignored and FINISH only pulses Done.

module block_transfer_sequencer #(
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              Start,
  input  logic              Load,
  input  logic              Up,
  input  logic              W,
  input  logic [3:0]        Rn,
  input  logic [DATA_W-1:0] Base,
  input  logic [15:0]       RegList,
  input  logic [DATA_W-1:0] RD,
  input  logic [DATA_W-1:0] MemRD,
  output logic [3:0]        RegA,
  output logic              RegWE,
  output logic [DATA_W-1:0] RegWD,
  output logic              PCWE,
  output logic [DATA_W-1:0] PCWD,
  output logic [DATA_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemWD,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] STRIDE = DATA_W'(WORD_BYTES);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         mask_q, mask_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic                load_q, load_d;

  // Request-side arithmetic; wraps modulo 2^DATA_W.
  logic [4:0]          n_req;
  logic [DATA_W-1:0]   span;
  assign n_req = popcount16(RegList);
  assign span  = STRIDE * DATA_W'(n_req);

  // Lowest pending register, and the mask with that bit removed.
  logic [3:0]          idx;
  logic [15:0]         mask_clr;
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q[i]) idx = 4'(i);
    end
  end
  assign mask_clr = mask_q & (mask_q - 16'd1);

`ifdef BLKXFER_WRITEBACK_EN
  // wb_q folds every suppression rule into one bit at Start time, so FINISH
  // never needs the original list.
  logic                wb_q, wb_d;
  logic [3:0]          rn_q, rn_d;
  logic [DATA_W-1:0]   newbase_q, newbase_d;
`else
  logic                unused_wb;
  assign unused_wb = ^{W, Rn};
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      addr_q    <= '0;
      load_q    <= 1'b0;
`ifdef BLKXFER_WRITEBACK_EN
      wb_q      <= 1'b0;
      rn_q      <= '0;
      newbase_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      load_q    <= load_d;
`ifdef BLKXFER_WRITEBACK_EN
      wb_q      <= wb_d;
      rn_q      <= rn_d;
      newbase_q <= newbase_d;
`endif
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    load_d    = load_q;
`ifdef BLKXFER_WRITEBACK_EN
    wb_d      = wb_q;
    rn_d      = rn_q;
    newbase_d = newbase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          load_d  = Load;
          mask_d  = RegList;
          addr_d  = Up ? Base : Base - span;
`ifdef BLKXFER_WRITEBACK_EN
          rn_d      = Rn;
          wb_d      = W && (Rn != 4'd15) && !(Load && RegList[Rn]);
          newbase_d = Up ? Base + span : Base - span;
`endif
          state_d = (n_req == 5'd0) ? S_FINISH : S_XFER;
        end
      end
      S_XFER: begin
        mask_d = mask_clr;
        addr_d = addr_q + STRIDE;
        if (mask_clr == 16'd0) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on state and captured registers (plus live read data).
  always_comb begin
    RegA    = '0;
    RegWE   = 1'b0;
    RegWD   = '0;
    PCWE    = 1'b0;
    PCWD    = '0;
    MemAddr = '0;
    MemWE   = 1'b0;
    MemWD   = '0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      S_XFER: begin
        Busy    = 1'b1;
        RegA    = idx;
        MemAddr = addr_q;
        if (!load_q) begin
          MemWE = 1'b1;
          MemWD = RD;
        end else if (idx == 4'd15) begin
          PCWE = 1'b1;
          PCWD = MemRD;
        end else begin
          RegWE = 1'b1;
          RegWD = MemRD;
        end
      end
      S_FINISH: begin
        Busy = 1'b1;
        Done = 1'b1;
`ifdef BLKXFER_WRITEBACK_EN
        if (wb_q) begin
          RegA  = rn_q;
          RegWE = 1'b1;
          RegWD = newbase_q;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
module tb_block_transfer_sequencer;

  logic        CLK = 1'b0;
  logic        reset, Start, Load, Up, W;
  logic [3:0]  Rn;
  logic [31:0] Base;
  logic [15:0] RegList;
  logic [31:0] RD, MemRD;
  logic [3:0]  RegA;
  logic        RegWE, PCWE, MemWE, Busy, Done;
  logic [31:0] RegWD, PCWD, MemAddr, MemWD;

  block_transfer_sequencer #(.DATA_W(32), .WORD_BYTES(4)) dut (
    .CLK(CLK), .reset(reset), .Start(Start), .Load(Load), .Up(Up), .W(W),
    .Rn(Rn), .Base(Base), .RegList(RegList), .RD(RD), .MemRD(MemRD),
    .RegA(RegA), .RegWE(RegWE), .RegWD(RegWD), .PCWE(PCWE), .PCWD(PCWD),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemWD(MemWD), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  // Environment: register file, PC and a 256-word memory indexed by address[9:2].
  logic [31:0] regs [16];
  logic [31:0] mem  [256];
  logic [31:0] pc;
  logic        tb_init;

  assign RD    = regs[RegA];
  assign MemRD = mem[MemAddr[9:2]];

  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++)  regs[i] <= 32'hA0A0_0000 | i;
      for (int i = 0; i < 256; i++) mem[i]  <= 32'hD000_0000 | i;
      pc <= 32'h0;
    end else begin
      if (MemWE) mem[MemAddr[9:2]] <= MemWD;
      if (RegWE) regs[RegA]        <= RegWD;
      if (PCWE)  pc                <= PCWD;
    end
  end

  // Scoreboard.
  typedef struct {
    bit          xfer;
    bit          fin;
    logic [3:0]  a;
    bit          regwe, memwe, pcwe;
    logic [31:0] regwd, pcwd, memaddr, memwd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, done_cyc = 0, accept_cyc = 0;
  bit   chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
  endtask

  exp_t ce;
  always @(negedge CLK) begin
    cyc++;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
        chk("busy", {31'd0, Busy}, 32'd1);
        chk("done", {31'd0, Done}, {31'd0, ce.fin});
        chk("regwe", {31'd0, RegWE}, {31'd0, ce.regwe});
        chk("memwe", {31'd0, MemWE}, {31'd0, ce.memwe});
        chk("pcwe", {31'd0, PCWE}, {31'd0, ce.pcwe});
        if (ce.xfer) begin
          chk("rega", {28'd0, RegA}, {28'd0, ce.a});
          chk("memaddr", MemAddr, ce.memaddr);
        end
        if (ce.regwe) begin
          chk("rega_wr", {28'd0, RegA}, {28'd0, ce.a});
          chk("regwd", RegWD, ce.regwd);
        end
        if (ce.memwe) chk("memwd", MemWD, ce.memwd);
        if (ce.pcwe)  chk("pcwd", PCWD, ce.pcwd);
        if (ce.fin)   done_cyc = cyc;
      end else begin
        chk("idle_busy", {31'd0, Busy}, 32'd0);
        chk("idle_done", {31'd0, Done}, 32'd0);
        chk("idle_strobes", {29'd0, RegWE, MemWE, PCWE}, 32'd0);
      end
    end
  end

  // Model: expected per-cycle activity of one transfer, from the list rules.
  task automatic build_exp(input bit load, input bit up, input bit w, input logic [3:0] rn,
                           input logic [31:0] base, input logic [15:0] list);
    exp_t        e;
    int          n;
    logic [31:0] addr;
    n    = $countones(list);
    addr = up ? base : base - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        e = '{default: 0};
        e.xfer = 1; e.a = 4'(i); e.memaddr = addr;
        if (!load) begin
          e.memwe = 1; e.memwd = regs[i];
        end else if (i == 15) begin
          e.pcwe = 1; e.pcwd = mem[addr[9:2]];
        end else begin
          e.regwe = 1; e.regwd = mem[addr[9:2]];
        end
        exp_q.push_back(e);
        addr = addr + 32'd4;
      end
    end
    e = '{default: 0};
    e.fin = 1;
`ifdef BLKXFER_WRITEBACK_EN
    if (w && rn != 4'd15 && !(load && list[rn])) begin
      e.regwe = 1; e.a = rn;
      e.regwd = up ? base + 32'(4 * n) : base - 32'(4 * n);
    end
`endif
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; Start high for one cycle, then inputs are scrambled.
  task automatic run(input bit load, input bit up, input bit w, input logic [3:0] rn,
                     input logic [31:0] base, input logic [15:0] list);
    Start = 1; Load = load; Up = up; W = w; Rn = rn; Base = base; RegList = list;
    @(posedge CLK); #1;
    Start = 0; Load = ~load; Up = ~up; W = ~w; Rn = ~rn; Base = ~base; RegList = ~list;
    accept_cyc = cyc;
    build_exp(load, up, w, rn, base, list);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge CLK);
    if (exp_q.size() != 0) begin
      chk("timeout_pending", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    tb_init = 1; reset = 1; Start = 0; Load = 0; Up = 0; W = 0;
    Rn = 0; Base = 0; RegList = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_strobes", {29'd0, RegWE, MemWE, PCWE}, 32'd0);
    chk("rst_rega", {28'd0, RegA}, 32'd0);
    chk("rst_regwd", RegWD, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memwd", MemWD, 32'd0);
    chk("rst_pcwd", PCWD, 32'd0);
    @(posedge CLK); #1;
    reset = 0; tb_init = 0; chk_en = 1;
    @(posedge CLK); #1;

    // STM increment-after with writeback to R13.
    run(0, 1, 1, 4'd13, 32'h100, 16'h0015);
    wait_idle();
    chk("stm_done_latency", done_cyc - accept_cyc, 32'd4);
    chk("stm_mem100", mem[8'h40], 32'hA0A0_0000);
    chk("stm_mem104", mem[8'h41], 32'hA0A0_0002);
    chk("stm_mem108", mem[8'h42], 32'hA0A0_0004);
`ifdef BLKXFER_WRITEBACK_EN
    chk("stm_r13_wb", regs[13], 32'h0000_010C);
`else
    chk("stm_r13_kept", regs[13], 32'hA0A0_000D);
`endif

    // LDM decrement-before into R0, R1 and PC; Start right after FINISH.
    run(1, 0, 0, 4'd0, 32'h200, 16'h8003);
    wait_idle();
    chk("ldm_r0", regs[0], 32'hD000_007D);
    chk("ldm_r1", regs[1], 32'hD000_007E);
    chk("ldm_pc", pc, 32'hD000_007F);

    // LDM with the base register in the list: loaded value wins.
    run(1, 1, 1, 4'd2, 32'h300, 16'h0006);
    wait_idle();
    chk("ldmbase_r1", regs[1], 32'hD000_00C0);
    chk("ldmbase_r2", regs[2], 32'hD000_00C1);

    // Empty list: FINISH only.
    run(0, 1, 1, 4'd5, 32'h40, 16'h0000);
    wait_idle();
    chk("empty_latency", done_cyc - accept_cyc, 32'd1);
`ifdef BLKXFER_WRITEBACK_EN
    chk("empty_r5_wb", regs[5], 32'h0000_0040);
`else
    chk("empty_r5_kept", regs[5], 32'hA0A0_0005);
`endif

    // Address wrap-around.
    run(0, 1, 0, 4'd0, 32'hFFFF_FFFC, 16'h0003);
    wait_idle();
    chk("wrap_memFFFFFFFC", mem[8'hFF], 32'hD000_007D);
    chk("wrap_mem00000000", mem[8'h00], 32'hD000_00C0);

    // Reset during the 5th XFER cycle of a full-list STM.
    run(0, 1, 0, 4'd0, 32'h80, 16'hFFFF);
    repeat (4) begin @(posedge CLK); #1; end
    reset = 1;
    @(posedge CLK); #1;
    reset = 0;
    exp_q.delete();
    @(posedge CLK); #1;
    chk("rst_xfer_r4_written", mem[8'h24], 32'hA0A0_0004);
    chk("rst_xfer_r5_abandoned", mem[8'h25], 32'hD000_0025);

    // A fresh transfer after the abandoned one runs normally.
    run(0, 1, 0, 4'd0, 32'h180, 16'h0081);
    wait_idle();
    chk("after_rst_mem180", mem[8'h60], 32'hD000_007D);
    chk("after_rst_mem184", mem[8'h61], 32'hA0A0_0007);
    chk("after_rst_latency", done_cyc - accept_cyc, 32'd3);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
